// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: header bytes, FSM state encoding,
// error codes and an address-width helper.
package uart_frame_parser_pkg;

    localparam logic [7:0] FRM_HDR0 = 8'h55;
    localparam logic [7:0] FRM_HDR1 = 8'hAA;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR2    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CSUM    = 3'd4,
        EMIT    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Address width for a buffer of 'depth' entries, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and one
// read port whose data output is registered (holds when rd_en is low).
module uart_frame_buf
    import uart_frame_parser_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    // Storage is deliberately not reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts 55 AA LEN PAYLOAD CSUM frames from a UART byte stream and releases the
// payload only after the checksum verifies. Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop,
    output logic       busy
);

    localparam int         AW        = addr_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] emit_idx_q, emit_idx_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic       rx_drop_q, rx_drop_d;

    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [7:0]    buf_rd_data;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int          TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (mclk),
        .srst    (rst),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data (rx_data),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        emit_idx_d  = emit_idx_q;
        frame_len_d = frame_len_q;
        err_code_d  = err_code_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_drop_d   = 1'b0;
        buf_wr_en   = 1'b0;
        buf_wr_addr = AW'(idx_q);
        buf_rd_en   = 1'b0;
        buf_rd_addr = AW'(emit_idx_q);

        unique case (state_q)
            IDLE: begin
                if (rx_done && rx_data == FRM_HDR0) begin
                    state_d = HDR2;
                end
            end
            HDR2: begin
                if (rx_done) begin
                    if (rx_data == FRM_HDR1) begin
                        state_d = LEN;
                    end else if (rx_data != FRM_HDR0) begin
                        state_d = IDLE;
                    end
                end
            end
            LEN: begin
                if (rx_done) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        idx_d   = 8'd0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_done) begin
                    buf_wr_en = 1'b1;
                    sum_d     = sum_q + rx_data;
                    idx_d     = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_done) begin
                    if (rx_data == sum_q) begin
                        // Launch the read of byte 0 now so it is on out_data next cycle.
                        state_d     = EMIT;
                        buf_rd_en   = 1'b1;
                        buf_rd_addr = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = (len_q == 8'd1);
                        frame_ok_d  = (len_q == 8'd1);
                        frame_len_d = len_q;
                        emit_idx_d  = 8'd1;
                    end else begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
            end
            EMIT: begin
                rx_drop_d = rx_done;
                if (emit_idx_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    buf_rd_en   = 1'b1;
                    out_valid_d = 1'b1;
                    out_last_d  = (emit_idx_q == len_q - 8'd1);
                    frame_ok_d  = (emit_idx_q == len_q - 8'd1);
                    emit_idx_d  = emit_idx_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        tmo_cnt_d = '0;
        if (state_q inside {HDR2, LEN, PAYLOAD, CSUM} && !rx_done) begin
            if (tmo_cnt_q == TMO_LAST) begin
                // Without rx_done the case above left state_d unchanged, so override it here.
                state_d     = IDLE;
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= 8'd0;
            idx_q       <= 8'd0;
            sum_q       <= 8'd0;
            emit_idx_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            frame_len_q <= 8'd0;
            rx_drop_q   <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            emit_idx_q  <= emit_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            frame_len_q <= frame_len_d;
            rx_drop_q   <= rx_drop_d;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign out_data  = buf_rd_data;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign frame_len = frame_len_q;
    assign rx_drop   = rx_drop_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected payload bytes and error events are
// queued as stimulus is driven and checked when the DUT emits them.
module tb_uart_frame_parser;

    localparam int MAXL = 16;
    localparam int TMO  = 100;

    logic       mclk    = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       rx_drop;
    logic       busy;

    uart_frame_parser #(
        .MAX_LEN     (MAXL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .frame_len (frame_len),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .rx_drop   (rx_drop),
        .busy      (busy)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } exp_t;

    typedef struct {
        logic [1:0] code;
        logic       tmo;
    } err_t;

    exp_t exp_q[$];
    err_t err_q[$];
    exp_t exp_e;
    err_t err_e;

    int   n_checks    = 0;
    int   n_fail      = 0;
    int   last_rx_cyc = 0;
    int   prev_cyc    = 0;
    int   n_drop_seen = 0;
    int   exp_drop    = 0;
    logic in_frame    = 1'b0;
    logic [7:0] pay [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_err(input logic [1:0] code, input logic tmo);
        err_t e;
        e.code = code;
        e.tmo  = tmo;
        err_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge mclk);
        rx_data     = b;
        rx_done     = 1'b1;
        last_rx_cyc = cyc + 1;
        @(negedge mclk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) @(negedge mclk);
    endtask

    // Builds a frame from pay[0..n-1]; a corrupt frame gets checksum+1.
    task automatic send_frame(input int n, input bit bad, input int csum_gap);
        logic [7:0] s;
        exp_t e;
        s = 8'(n);
        for (int i = 0; i < n; i++) s = s + pay[i];
        if (bad) begin
            push_err(2'd2, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) begin
                e.data = pay[i];
                e.last = (i == n - 1);
                e.len  = 8'(n);
                exp_q.push_back(e);
            end
        end
        $display("tx frame len=%0d csum=%02h %s", n, bad ? s + 8'd1 : s, bad ? "corrupt" : "good");
        send_byte(8'h55, $urandom_range(0, 2));
        send_byte(8'hAA, $urandom_range(0, 2));
        send_byte(8'(n), $urandom_range(0, 2));
        for (int i = 0; i < n; i++) send_byte(pay[i], $urandom_range(0, 2));
        send_byte(bad ? s + 8'd1 : s, csum_gap);
    endtask

    task automatic check_outputs_zero();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last",  out_last,  0);
        check("rst_frame_ok",  frame_ok,  0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code",  err_code,  0);
        check("rst_rx_drop",   rx_drop,   0);
        check("rst_out_data",  out_data,  0);
        check("rst_frame_len", frame_len, 0);
        check("rst_busy",      busy,      0);
    endtask

    task automatic pulse_reset(input logic exp_busy);
        @(negedge mclk);
        check("pre_rst_busy", busy, exp_busy);
        rst = 1'b1;
        @(negedge mclk);
        check_outputs_zero();
        rst = 1'b0;
        exp_q.delete();
        err_q.delete();
        in_frame = 1'b0;
        $display("reset pulse applied at cycle %0d", cyc);
    endtask

    // Output monitor: pops the scoreboard on every emitted byte and error pulse.
    always @(negedge mclk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_data",  out_data,  exp_e.data);
                    check("out_last",  out_last,  exp_e.last);
                    check("frame_ok",  frame_ok,  exp_e.last);
                    check("frame_len", frame_len, exp_e.len);
                    if (!in_frame) check("first_byte_latency", cyc - last_rx_cyc, 0);
                    else           check("byte_spacing", cyc - prev_cyc, 1);
                    prev_cyc = cyc;
                    in_frame = !out_last;
                end
            end else if (out_last || frame_ok) begin
                check("strobe_without_valid", {out_last, frame_ok}, 0);
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_err", 1, 0);
                end else begin
                    err_e = err_q.pop_front();
                    check("err_code", err_code, err_e.code);
                    if (err_e.tmo) check("timeout_latency", cyc - last_rx_cyc, TMO);
                    else           check("err_latency", cyc - last_rx_cyc, 0);
                end
            end
            if (rx_drop) n_drop_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(negedge mclk);
        check_outputs_zero();
        rst = 1'b0;

        // Reference frame and its corrupted twin, then recovery
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(3, 1'b0, 5);
        send_frame(3, 1'b1, 5);
        send_frame(3, 1'b0, 5);

        // Illegal LEN values
        foreach (pay[i]) if (i < 2) pay[i] = 8'h00;
        push_err(2'd1, 1'b0);
        $display("tx LEN=00");
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h00, 3);
        push_err(2'd1, 1'b0);
        $display("tx LEN=11");
        send_byte(8'h55, 1); send_byte(8'hAA, 1); send_byte(8'h11, 3);

        // Maximum length with a wrapping checksum
        for (int i = 0; i < MAXL; i++) pay[i] = 8'hFF;
        send_frame(MAXL, 1'b0, MAXL + 2);

        // Resync on repeated 55
        exp_e.data = 8'h7E; exp_e.last = 1'b1; exp_e.len = 8'd1;
        exp_q.push_back(exp_e);
        $display("tx resync 55 55 AA 01 7E 7F");
        send_byte(8'h55, 1); send_byte(8'h55, 1); send_byte(8'hAA, 1);
        send_byte(8'h01, 1); send_byte(8'h7E, 1); send_byte(8'h7F, 4);

        // Garbage after first 55 drops back to IDLE without an error
        $display("tx garbage 55 12 AA 01 7E 7F");
        send_byte(8'h55, 1); send_byte(8'h12, 1); send_byte(8'hAA, 1);
        send_byte(8'h01, 1); send_byte(8'h7E, 1); send_byte(8'h7F, 4);
        check("garbage_idle", busy, 0);

        // Random frames, some corrupted
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, MAXL);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            send_frame(n, ($urandom_range(0, 3) == 0), n + 2);
        end

        // Byte arriving during EMIT is dropped; emission is unaffected
        for (int i = 0; i < MAXL; i++) pay[i] = 8'(i * 7 + 3);
        send_frame(MAXL, 1'b0, 0);
        repeat (2) @(negedge mclk);
        exp_drop++;
        $display("tx byte during EMIT");
        send_byte(8'h55, MAXL + 4);
        check("busy_after_drop", busy, 0);

        // Reset in PAYLOAD
        $display("tx partial frame then reset");
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h04, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        pulse_reset(1'b1);

        // Reset in EMIT
        for (int i = 0; i < MAXL; i++) pay[i] = 8'(8'hA0 + i);
        send_frame(MAXL, 1'b0, 0);
        repeat (2) @(negedge mclk);
        pulse_reset(1'b1);
        repeat (MAXL + 2) @(negedge mclk);

        // Recovery after reset
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        send_frame(2, 1'b0, 4);

        // Stalled frame
        $display("tx stalled frame 55 AA 02 10");
`ifdef UART_FRAME_TIMEOUT_EN
        push_err(2'd3, 1'b1);
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
        repeat (TMO + 20) @(negedge mclk);
        check("timeout_idle", busy, 0);
        pulse_reset(1'b0);
`else
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
        repeat (TMO + 20) @(negedge mclk);
        check("no_timeout_busy", busy, 1);
        pulse_reset(1'b1);
`endif

        w = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && w < 200) begin
            @(negedge mclk);
            w++;
        end
        check("exp_q_drained", exp_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        check("rx_drop_count", n_drop_seen, exp_drop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
